// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: default field widths, control-word
// bit positions and slot indices reused by every stage register.
package pipe_pkg;

  // Default field widths
  localparam int DATA_W_DEF = 19;
  localparam int PC_W_DEF   = 15;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W_DEF = 11;

  // Packed control word: {Cant_Byte, ALUControl[2:0], ResultSrc, ALUSrc,
  //                       Branch[1:0], Jump, MemWrite, RegWrite}
  localparam int CTRL_REGWRITE_BIT  = 0;
  localparam int CTRL_MEMWRITE_BIT  = 1;
  localparam int CTRL_JUMP_BIT      = 2;
  localparam int CTRL_BRANCH_LO     = 3;
  localparam int CTRL_BRANCH_HI     = 4;
  localparam int CTRL_ALUSRC_BIT    = 5;
  localparam int CTRL_RESULTSRC_BIT = 6;
  localparam int CTRL_ALUCTRL_LO    = 7;
  localparam int CTRL_ALUCTRL_HI    = 9;
  localparam int CTRL_CANTBYTE_BIT  = 10;

  // Operand-bypass slots inside a two-entry skid register
  typedef enum logic [1:0] {
    SLOT_MAIN = 2'd0,
    SLOT_SKID = 2'd1,
    SLOT_IN   = 2'd2
  } slot_e;

  localparam int NUM_SLOTS = 3;

endpackage

// File: rtl/pipe_entry_bypass.sv
// Writeback bypass for one entry: replaces an operand with the writeback
// data when the entry's source address matches the register being written.
module pipe_entry_bypass #(
  parameter int DATA_W = 19,
  parameter int REG_AW = 5
) (
  input  logic              en,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out
);

  logic hit1;
  logic hit2;

  // Compare both sources independently; address 0 is not special-cased
  always_comb begin
    hit1    = en & wb_we & (wb_rd == rs1);
    hit2    = en & wb_we & (wb_rd == rs2);
    rd1_out = hit1 ? wb_data : rd1_in;
    rd2_out = hit2 ? wb_data : rd2_in;
  end

endmodule

// File: rtl/decode_pipe_reg.sv
// Decode -> execute pipeline register built as a two-entry skid buffer with
// writeback bypass on capture and writeback refresh of held entries.
module decode_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [PC_W-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2
);

  localparam int IM = int'(SLOT_MAIN);
  localparam int IS = int'(SLOT_SKID);
  localparam int II = int'(SLOT_IN);

  // Valid bits and registered ready
  logic main_v_q, main_v_d;
  logic skid_v_q, skid_v_d;
  logic in_ready_q, in_ready_d;

  // Main entry (drives outputs)
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_rd1_q, main_rd1_d;
  logic [DATA_W-1:0] main_rd2_q, main_rd2_d;
  logic [DATA_W-1:0] main_imm_q, main_imm_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [REG_AW-1:0] main_rd_q, main_rd_d;
  logic [REG_AW-1:0] main_rs1_q, main_rs1_d;
  logic [REG_AW-1:0] main_rs2_q, main_rs2_d;

  // Skid entry (catches the instruction accepted while main is held)
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_rd1_q, skid_rd1_d;
  logic [DATA_W-1:0] skid_rd2_q, skid_rd2_d;
  logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [REG_AW-1:0] skid_rd_q, skid_rd_d;
  logic [REG_AW-1:0] skid_rs1_q, skid_rs1_d;
  logic [REG_AW-1:0] skid_rs2_q, skid_rs2_d;

  // Bypass slot wiring: main, skid, incoming
  logic              byp_en      [NUM_SLOTS];
  logic [REG_AW-1:0] byp_rs1     [NUM_SLOTS];
  logic [REG_AW-1:0] byp_rs2     [NUM_SLOTS];
  logic [DATA_W-1:0] byp_rd1_in  [NUM_SLOTS];
  logic [DATA_W-1:0] byp_rd2_in  [NUM_SLOTS];
  logic [DATA_W-1:0] byp_rd1_out [NUM_SLOTS];
  logic [DATA_W-1:0] byp_rd2_out [NUM_SLOTS];

  logic accept_in;
  logic main_pop;

  // Held entries refresh only while valid so an empty main keeps its last data
  assign byp_en[IM]     = main_v_q;
  assign byp_rs1[IM]    = main_rs1_q;
  assign byp_rs2[IM]    = main_rs2_q;
  assign byp_rd1_in[IM] = main_rd1_q;
  assign byp_rd2_in[IM] = main_rd2_q;

  assign byp_en[IS]     = skid_v_q;
  assign byp_rs1[IS]    = skid_rs1_q;
  assign byp_rs2[IS]    = skid_rs2_q;
  assign byp_rd1_in[IS] = skid_rd1_q;
  assign byp_rd2_in[IS] = skid_rd2_q;

  assign byp_en[II]     = 1'b1;
  assign byp_rs1[II]    = in_rs1;
  assign byp_rs2[II]    = in_rs2;
  assign byp_rd1_in[II] = in_rd1;
  assign byp_rd2_in[II] = in_rd2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_byp
      pipe_entry_bypass #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
      ) u_byp (
        .en      (byp_en[gi]),
        .rs1     (byp_rs1[gi]),
        .rs2     (byp_rs2[gi]),
        .rd1_in  (byp_rd1_in[gi]),
        .rd2_in  (byp_rd2_in[gi]),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rd1_out (byp_rd1_out[gi]),
        .rd2_out (byp_rd2_out[gi])
      );
    end
  endgenerate

  assign accept_in = in_valid & in_ready_q;
  assign main_pop  = main_v_q & out_ready;

  // Next-state selection: shift skid into main, capture incoming, or hold
  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_rd1_d  = byp_rd1_out[IM];
    main_rd2_d  = byp_rd2_out[IM];
    main_imm_d  = main_imm_q;
    main_pc_d   = main_pc_q;
    main_rd_d   = main_rd_q;
    main_rs1_d  = main_rs1_q;
    main_rs2_d  = main_rs2_q;

    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_rd1_d  = byp_rd1_out[IS];
    skid_rd2_d  = byp_rd2_out[IS];
    skid_imm_d  = skid_imm_q;
    skid_pc_d   = skid_pc_q;
    skid_rd_d   = skid_rd_q;
    skid_rs1_d  = skid_rs1_q;
    skid_rs2_d  = skid_rs2_q;

    if (!main_v_q || main_pop) begin
      if (skid_v_q) begin
        // Oldest instruction is in skid: it moves up, incoming backfills skid
        main_v_d    = 1'b1;
        main_ctrl_d = skid_ctrl_q;
        main_rd1_d  = byp_rd1_out[IS];
        main_rd2_d  = byp_rd2_out[IS];
        main_imm_d  = skid_imm_q;
        main_pc_d   = skid_pc_q;
        main_rd_d   = skid_rd_q;
        main_rs1_d  = skid_rs1_q;
        main_rs2_d  = skid_rs2_q;
        skid_v_d    = accept_in;
        if (accept_in) begin
          skid_ctrl_d = in_ctrl;
          skid_rd1_d  = byp_rd1_out[II];
          skid_rd2_d  = byp_rd2_out[II];
          skid_imm_d  = in_imm;
          skid_pc_d   = in_pc;
          skid_rd_d   = in_rd;
          skid_rs1_d  = in_rs1;
          skid_rs2_d  = in_rs2;
        end
      end else begin
        main_v_d = accept_in;
        if (accept_in) begin
          main_ctrl_d = in_ctrl;
          main_rd1_d  = byp_rd1_out[II];
          main_rd2_d  = byp_rd2_out[II];
          main_imm_d  = in_imm;
          main_pc_d   = in_pc;
          main_rd_d   = in_rd;
          main_rs1_d  = in_rs1;
          main_rs2_d  = in_rs2;
        end
      end
    end else if (accept_in) begin
      // Main is stalled: park the incoming instruction in skid
      skid_v_d    = 1'b1;
      skid_ctrl_d = in_ctrl;
      skid_rd1_d  = byp_rd1_out[II];
      skid_rd2_d  = byp_rd2_out[II];
      skid_imm_d  = in_imm;
      skid_pc_d   = in_pc;
      skid_rd_d   = in_rd;
      skid_rs1_d  = in_rs1;
      skid_rs2_d  = in_rs2;
    end

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end

    in_ready_d = ~skid_v_d;
  end

  // State registers; reset clears every valid bit and stored field
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_rd1_q  <= '0;
      main_rd2_q  <= '0;
      main_imm_q  <= '0;
      main_pc_q   <= '0;
      main_rd_q   <= '0;
      main_rs1_q  <= '0;
      main_rs2_q  <= '0;
      skid_ctrl_q <= '0;
      skid_rd1_q  <= '0;
      skid_rd2_q  <= '0;
      skid_imm_q  <= '0;
      skid_pc_q   <= '0;
      skid_rd_q   <= '0;
      skid_rs1_q  <= '0;
      skid_rs2_q  <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_rd1_q  <= main_rd1_d;
      main_rd2_q  <= main_rd2_d;
      main_imm_q  <= main_imm_d;
      main_pc_q   <= main_pc_d;
      main_rd_q   <= main_rd_d;
      main_rs1_q  <= main_rs1_d;
      main_rs2_q  <= main_rs2_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_rd1_q  <= skid_rd1_d;
      skid_rd2_q  <= skid_rd2_d;
      skid_imm_q  <= skid_imm_d;
      skid_pc_q   <= skid_pc_d;
      skid_rd_q   <= skid_rd_d;
      skid_rs1_q  <= skid_rs1_d;
      skid_rs2_q  <= skid_rs2_d;
    end
  end

  // Bubbles carry an all-zero control word
  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_ctrl  = main_v_q ? main_ctrl_q : '0;
  assign out_rd1   = main_rd1_q;
  assign out_rd2   = main_rd2_q;
  assign out_imm   = main_imm_q;
  assign out_pc    = main_pc_q;
  assign out_rd    = main_rd_q;
  assign out_rs1   = main_rs1_q;
  assign out_rs2   = main_rs2_q;

endmodule

// File: tb/tb_decode_pipe_reg.sv
// Directed testbench for decode_pipe_reg: streaming, stall/skid, bypass,
// refresh, flush and reset, each with hand-derived expected values.
module tb_decode_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_ctrl;
  logic [18:0] in_rd1, in_rd2, in_imm;
  logic [14:0] in_pc;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [18:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_ctrl;
  logic [18:0] out_rd1, out_rd2, out_imm;
  logic [14:0] out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  int checks   = 0;
  int failures = 0;

  decode_pipe_reg dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_rd1    (in_rd1),
    .in_rd2    (in_rd2),
    .in_imm    (in_imm),
    .in_pc     (in_pc),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_rd1   (out_rd1),
    .out_rd2   (out_rd2),
    .out_imm   (out_imm),
    .out_pc    (out_pc),
    .out_rd    (out_rd),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2)
  );

  always #5 clk = ~clk;

  // Stimulus encoding: control word and immediate are derived from the PC
  function automatic logic [10:0] ctrl_of(input int pc);
    return 11'(32'h401 + pc);
  endfunction

  function automatic logic [18:0] imm_of(input int pc);
    return 19'(32'h100 + pc);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input int pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [18:0] rd1, input logic [18:0] rd2);
    in_valid = v;
    in_pc    = 15'(pc);
    in_ctrl  = ctrl_of(pc);
    in_imm   = imm_of(pc);
    in_rd    = 5'(pc >> 2);
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd1   = rd1;
    in_rd2   = rd2;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [18:0] data);
    wb_we   = we;
    wb_rd   = rd;
    wb_data = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 5'd0, 5'd0, 19'd0, 19'd0);
    wb(1'b0, 5'd0, 19'd0);
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_out_rd1", 32'(out_rd1), 32'd0);
    reset = 1'b0;
    tick();

    // Streaming: pc 0,4,8,12, one cycle after each accept
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4 * i, 5'(i + 1), 5'(i + 2), 19'(i + 16), 19'(i + 32));
      tick();
      check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d_pc", i), 32'(out_pc), 32'(4 * i));
      check($sformatf("stream%0d_ctrl", i), 32'(out_ctrl), 32'(ctrl_of(4 * i)));
      check($sformatf("stream%0d_rd1", i), 32'(out_rd1), 32'(i + 16));
      check($sformatf("stream%0d_ready", i), 32'(in_ready), 32'd1);
    end
    drive(1'b0, 0, 5'd0, 5'd0, 19'd0, 19'd0);
    tick();
    check("stream_bubble_valid", 32'(out_valid), 32'd0);
    check("stream_bubble_ctrl", 32'(out_ctrl), 32'd0);
    check("stream_bubble_pc_hold", 32'(out_pc), 32'd12);

    // Stall: skid takes pc 4, in_ready drops, release drains in order
    out_ready = 1'b0;
    drive(1'b1, 0, 5'd1, 5'd2, 19'd1, 19'd2);
    tick();
    check("stall_pc0", 32'(out_pc), 32'd0);
    check("stall_ready0", 32'(in_ready), 32'd1);
    drive(1'b1, 4, 5'd1, 5'd2, 19'd3, 19'd4);
    tick();
    check("stall_ready_low", 32'(in_ready), 32'd0);
    check("stall_pc0_held", 32'(out_pc), 32'd0);
    check("stall_ctrl_held", 32'(out_ctrl), 32'(ctrl_of(0)));
    drive(1'b1, 8, 5'd1, 5'd2, 19'd5, 19'd6);
    out_ready = 1'b1;
    tick();
    check("drain_pc4", 32'(out_pc), 32'd4);
    check("drain_rd1_4", 32'(out_rd1), 32'd3);
    check("drain_ready", 32'(in_ready), 32'd1);
    tick();
    check("drain_pc8", 32'(out_pc), 32'd8);
    check("drain_valid8", 32'(out_valid), 32'd1);
    drive(1'b0, 0, 5'd0, 5'd0, 19'd0, 19'd0);
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Capture bypass on rs1, and on address 0 for both operands
    drive(1'b1, 16, 5'd3, 5'd4, 19'h00011, 19'h00022);
    wb(1'b1, 5'd3, 19'h7ABCD);
    tick();
    check("byp_rd1", 32'(out_rd1), 32'h7ABCD);
    check("byp_rd2_untouched", 32'(out_rd2), 32'h00022);
    drive(1'b1, 20, 5'd0, 5'd0, 19'h00033, 19'h00044);
    wb(1'b1, 5'd0, 19'h12345);
    tick();
    check("byp_x0_rd1", 32'(out_rd1), 32'h12345);
    check("byp_x0_rd2", 32'(out_rd2), 32'h12345);
    wb(1'b0, 5'd0, 19'd0);
    drive(1'b0, 0, 5'd0, 5'd0, 19'd0, 19'd0);
    tick();

    // Refresh of held main and skid entries
    out_ready = 1'b0;
    drive(1'b1, 24, 5'd1, 5'd7, 19'h00001, 19'h00002);
    tick();
    check("hold_rd2_pre", 32'(out_rd2), 32'h00002);
    drive(1'b0, 0, 5'd0, 5'd0, 19'd0, 19'd0);
    wb(1'b1, 5'd7, 19'h00055);
    tick();
    check("refresh_rd2", 32'(out_rd2), 32'h00055);
    check("refresh_rd1_kept", 32'(out_rd1), 32'h00001);
    check("refresh_pc_kept", 32'(out_pc), 32'd24);
    check("refresh_imm_kept", 32'(out_imm), 32'(imm_of(24)));
    wb(1'b0, 5'd0, 19'd0);
    drive(1'b1, 28, 5'd7, 5'd9, 19'h00009, 19'h0000A);
    tick();
    drive(1'b0, 0, 5'd0, 5'd0, 19'd0, 19'd0);
    wb(1'b1, 5'd7, 19'h00066);
    tick();
    check("refresh_main_rd2", 32'(out_rd2), 32'h00066);
    wb(1'b0, 5'd0, 19'd0);
    out_ready = 1'b1;
    tick();
    check("skid_refresh_pc", 32'(out_pc), 32'd28);
    check("skid_refresh_rd1", 32'(out_rd1), 32'h00066);
    check("skid_refresh_rd2", 32'(out_rd2), 32'h0000A);
    check("skid_refresh_rd", 32'(out_rd), 32'd7);
    tick();
    check("refresh_empty", 32'(out_valid), 32'd0);

    // Flush with both entries full and an incoming instruction
    out_ready = 1'b0;
    drive(1'b1, 32, 5'd1, 5'd2, 19'd1, 19'd2);
    tick();
    drive(1'b1, 36, 5'd1, 5'd2, 19'd1, 19'd2);
    tick();
    check("flush_pre_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 40, 5'd1, 5'd2, 19'd1, 19'd2);
    flush = 1'b1;
    tick();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ctrl", 32'(out_ctrl), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 44, 5'd5, 5'd6, 19'h00077, 19'h00088);
    tick();
    check("post_flush_valid", 32'(out_valid), 32'd1);
    check("post_flush_pc", 32'(out_pc), 32'd44);
    check("post_flush_ctrl", 32'(out_ctrl), 32'(ctrl_of(44)));
    drive(1'b0, 0, 5'd0, 5'd0, 19'd0, 19'd0);
    tick();
    check("post_flush_empty", 32'(out_valid), 32'd0);

    // Reset with both entries full
    out_ready = 1'b0;
    drive(1'b1, 48, 5'd3, 5'd4, 19'd5, 19'd6);
    tick();
    drive(1'b1, 52, 5'd3, 5'd4, 19'd5, 19'd6);
    tick();
    check("rst2_pre_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_ready", 32'(in_ready), 32'd1);
    check("rst2_ctrl", 32'(out_ctrl), 32'd0);
    check("rst2_pc", 32'(out_pc), 32'd0);
    check("rst2_rd1", 32'(out_rd1), 32'd0);
    check("rst2_imm", 32'(out_imm), 32'd0);
    check("rst2_rs1", 32'(out_rs1), 32'd0);
    check("rst2_rs2", 32'(out_rs2), 32'd0);
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 0, 5'd0, 5'd0, 19'd0, 19'd0);
    out_ready = 1'b1;
    tick();
    check("rst2_stays_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
